sv_latch_bank_scan: RTL and testbench
=====================================

Name: sv_latch_bank_scan

Overview:
- Parametrised multi-channel successor to the single-channel data latch.
- CHANNELS independent WIDTH-bit holding registers, fully flop-based (no inferred latches), each with a per-channel enable.
- Global mode selects transparent-follow, edge-sample or freeze behaviour.
- Sticky capture/overrun flags and a round-robin valid/ready readout FSM stream newly captured channel values to a downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel (≥1).
- CHANNELS, 4, number of channels (≥2).
- CH_W, $clog2(CHANNELS), channel index width (derived, localparam).

Ports:
- clk  in  1  clock, all state rises on posedge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of all data, flags and readout.
- mode  in  2  00 FOLLOW, 01 SAMPLE, 10 FREEZE, 11 treated as FREEZE.
- enable  in  CHANNELS  per-channel capture enable.
- data_in  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
- data_out  out  CHANNELS*WIDTH  held value per channel, same packing.
- captured  out  CHANNELS  sticky: channel holds unread new value.
- overrun  out  CHANNELS  sticky: capture hit a channel whose captured bit was still set.
- rd_valid  out  1  readout word valid.
- rd_ready  in  1  consumer accepts word.
- rd_chan  out  CH_W  channel index of readout word.
- rd_data  out  WIDTH  snapshot of that channel's value.

Behaviour:
- Reset (async) and clear (sync, next edge): data_out, captured, overrun, rd_data, rd_chan, rd_valid = 0; scan pointer = 0; FSM = IDLE.
- Reset has priority over clear, and clear over all other activity.
- Capture event per channel c, evaluated at each posedge:
  - FOLLOW: event when enable[c]=1.
  - SAMPLE: event only on the 0→1 transition of enable[c], detected against a registered enable_d[c]; enable_d resets to 0.
  - FREEZE: no events. enable_d still tracks enable, so leaving FREEZE while enable is high gives no spurious SAMPLE edge.
- On a capture event: data_out[c] ← data_in[c] and captured[c] ← 1, visible one cycle after the sampling edge. If captured[c] was already 1, overrun[c] ← 1 as well.
- Readout FSM states:
  - IDLE: if any captured bit is set, select the lowest index ≥ ptr, wrapping to 0 if none. Load rd_chan ← index and rd_data ← data_out[index] (the registered value at that edge). Go to PRESENT with rd_valid = 1 on the next cycle.
  - PRESENT: rd_valid, rd_chan and rd_data stay stable until rd_valid && rd_ready. On handshake: rd_valid ← 0, captured[rd_chan] ← 0, ptr ← rd_chan+1 (wrapping CHANNELS-1 → 0), go to IDLE.
- Throughput: at most one word per 2 cycles.
- Capture and handshake on the same channel in the same cycle: the capture wins. captured stays 1, no overrun is flagged, and the new value is presented on a later scan.
- Captures to the presented channel while in PRESENT do not alter rd_data (snapshot).
- clear during PRESENT aborts the word (rd_valid drops next cycle). This is the only permitted valid withdrawal.
- A mode change takes effect on the next edge and never affects the FSM.

Decomposition:
- Package sv_latch_bank_pkg holds:
  - typedef enum logic [1:0] latch_mode_e {MODE_FOLLOW, MODE_SAMPLE, MODE_FREEZE, MODE_RSVD};
  - typedef enum logic [0:0] scan_state_e {SCAN_IDLE, SCAN_PRESENT}.
- Sub-module sv_rr_pick (CHANNELS param): combinational round-robin picker taking request vector and ptr, returning any and index.

Test Plan:
- Reset mid-operation: assert reset while rd_valid=1 → all outputs 0 immediately; after release, captured=0 and no rd_valid.
- FOLLOW, CHANNELS=4, WIDTH=8: enable=0001 for 3 cycles with data ch0 = 0x11, 0x22, 0x33 → data_out ch0 tracks with 1-cycle latency, ending at 0x33. overrun[0]=1 because rd_ready=0.
- SAMPLE: hold enable[2]=1 for 5 cycles with data_in ch2 changing 0xA0..0xA4 → exactly one capture of 0xA0; captured=0100; rd_valid with rd_chan=2, rd_data=0xA0.
- Round robin: captures on ch1 and ch3 together, rd_ready=1 → words ch1 then ch3. Recapture ch1 and ch0 → ch0 is served next, since ptr=0 after the ch3 wrap.
- Backpressure and snapshot: ch0 presented as 0x55 with rd_ready=0 for 4 cycles while ch0 recaptures 0x66 → rd_data stays 0x55 and overrun[0]=1. Handshake → captured[0] stays 1 if the same-cycle capture occurred (no new overrun from that collision), else clears; a later capture of 0x66 is then presented.
- FREEZE plus clear: mode=10 with enables toggling → data_out unchanged. Assert clear during PRESENT → next cycle rd_valid=0, and data_out, captured and overrun all 0.

Source files
------------

// File: rtl/sv_latch_bank_pkg.sv
// Shared types for the multi-channel latch bank and its readout scanner.
package sv_latch_bank_pkg;

  // Global capture behaviour; the reserved code behaves like FREEZE.
  typedef enum logic [1:0] {
    MODE_FOLLOW = 2'b00,
    MODE_SAMPLE = 2'b01,
    MODE_FREEZE = 2'b10,
    MODE_RSVD   = 2'b11
  } latch_mode_e;

  // Readout scanner: either looking for work or holding a word for the consumer.
  typedef enum logic [0:0] {
    SCAN_IDLE    = 1'b0,
    SCAN_PRESENT = 1'b1
  } scan_state_e;

endpackage

// File: rtl/sv_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module sv_rr_pick #(
  parameter  int CHANNELS = 4,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     ptr,
  output logic                any,
  output logic [CH_W-1:0]     idx
);

  // Walk the channels starting at ptr and keep the first requester found.
  always_comb begin
    int c;
    logic [CH_W-1:0] cand;
    any  = 1'b0;
    idx  = '0;
    c    = 0;
    cand = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      c = int'(ptr) + i;
      if (c >= CHANNELS) c = c - CHANNELS;
      cand = CH_W'(c);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/sv_latch_bank_scan.sv
// Multi-channel flop-based holding bank with sticky capture/overrun flags and
// a round-robin valid/ready readout of newly captured channel values.
module sv_latch_bank_scan
  import sv_latch_bank_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       captured,
  output logic [CHANNELS-1:0]       overrun,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [CH_W-1:0]           rd_chan,
  output logic [WIDTH-1:0]          rd_data
);

  scan_state_e         state;
  logic [CH_W-1:0]     ptr;
  logic [CHANNELS-1:0] enable_d;
  logic [CHANNELS-1:0] cap_ev;
  logic [CHANNELS-1:0] hs_mask;
  logic                hs;
  logic                pick_any;
  logic [CH_W-1:0]     pick_idx;
  logic [CH_W-1:0]     ptr_next;

  assign hs       = (state == SCAN_PRESENT) && rd_ready;
  assign ptr_next = (rd_chan == CH_W'(CHANNELS - 1)) ? '0 : rd_chan + 1'b1;

  // Per-channel capture events for the current mode.
  always_comb begin
    cap_ev = '0;
    case (latch_mode_e'(mode))
      MODE_FOLLOW: cap_ev = enable;
      MODE_SAMPLE: cap_ev = enable & ~enable_d;
      default:     cap_ev = '0;
    endcase
  end

  // One-hot of the channel whose word is being accepted this cycle.
  always_comb begin
    hs_mask = '0;
    if (hs) hs_mask[rd_chan] = 1'b1;
  end

  sv_rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .req (captured),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Enable history for edge detection; it keeps tracking through clear and
  // FREEZE so a later switch to SAMPLE only reacts to genuine rising edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) enable_d <= '0;
    else       enable_d <= enable;
  end

  // Holding registers: load the channel's input on its capture event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (clear) begin
      data_out <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cap_ev[c]) data_out[c*WIDTH +: WIDTH] <= data_in[c*WIDTH +: WIDTH];
      end
    end
  end

  // Sticky flags; a capture colliding with the accept of the same channel
  // keeps the channel pending and is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      captured <= '0;
      overrun  <= '0;
    end else if (clear) begin
      captured <= '0;
      overrun  <= '0;
    end else begin
      captured <= (captured & ~hs_mask) | cap_ev;
      overrun  <= overrun | (cap_ev & captured & ~hs_mask);
    end
  end

  // Readout scanner: snapshot a pending channel, hold it until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SCAN_IDLE;
      rd_valid <= 1'b0;
      rd_chan  <= '0;
      rd_data  <= '0;
      ptr      <= '0;
    end else if (clear) begin
      state    <= SCAN_IDLE;
      rd_valid <= 1'b0;
      rd_chan  <= '0;
      rd_data  <= '0;
      ptr      <= '0;
    end else begin
      case (state)
        SCAN_IDLE: begin
          if (pick_any) begin
            state    <= SCAN_PRESENT;
            rd_valid <= 1'b1;
            rd_chan  <= pick_idx;
            rd_data  <= data_out[int'(pick_idx)*WIDTH +: WIDTH];
          end
        end
        SCAN_PRESENT: begin
          if (rd_ready) begin
            state    <= SCAN_IDLE;
            rd_valid <= 1'b0;
            ptr      <= ptr_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sv_latch_bank_scan.sv
// Bench for sv_latch_bank_scan: directed scenarios plus random traffic, every
// cycle compared against a channel-array reference model.
module tb_sv_latch_bank_scan;
  localparam int W  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clear = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic [CH-1:0]   enable = '0;
  logic [CH*W-1:0] data_in = '0;
  logic [CH*W-1:0] data_out;
  logic [CH-1:0]   captured;
  logic [CH-1:0]   overrun;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [1:0]      rd_chan;
  logic [W-1:0]    rd_data;

  sv_latch_bank_scan #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode), .enable(enable),
    .data_in(data_in), .data_out(data_out), .captured(captured),
    .overrun(overrun), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_chan(rd_chan), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int words[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one entry per channel, plus the word on offer.
  logic [W-1:0] m_data[CH];
  bit           m_cap[CH];
  bit           m_ovr[CH];
  bit           m_end[CH];
  bit           m_valid;
  int           m_chan;
  int           m_ptr;
  logic [W-1:0] m_rdata;

  task automatic m_clear_state();
    for (int c = 0; c < CH; c++) begin
      m_data[c] = '0; m_cap[c] = 0; m_ovr[c] = 0;
    end
    m_valid = 0; m_chan = 0; m_ptr = 0; m_rdata = '0;
  endtask

  task automatic m_reset();
    m_clear_state();
    for (int c = 0; c < CH; c++) m_end[c] = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_step();
    bit hs;
    bit ev;
    int chan0;
    int pick;
    int c;
    hs    = m_valid && rd_ready;
    chan0 = m_chan;
    if (clear) begin
      m_clear_state();
    end else begin
      if (!m_valid) begin
        pick = -1;
        for (int k = 0; k < CH; k++) begin
          c = (m_ptr + k) % CH;
          if (pick < 0 && m_cap[c]) pick = c;
        end
        if (pick >= 0) begin
          m_valid = 1; m_chan = pick; m_rdata = m_data[pick];
        end
      end else if (hs) begin
        m_valid = 0;
        m_ptr = (chan0 + 1) % CH;
      end
      for (int i = 0; i < CH; i++) begin
        if (mode == 2'b00)      ev = enable[i];
        else if (mode == 2'b01) ev = enable[i] && !m_end[i];
        else                    ev = 0;
        if (ev) begin
          if (m_cap[i] && !(hs && chan0 == i)) m_ovr[i] = 1;
          m_cap[i]  = 1;
          m_data[i] = data_in[i*W +: W];
        end else if (hs && chan0 == i) begin
          m_cap[i] = 0;
        end
      end
    end
    for (int i = 0; i < CH; i++) m_end[i] = enable[i];
  endtask

  task automatic compare();
    logic [CH*W-1:0] e_do;
    logic [CH-1:0]   e_cap, e_ovr;
    for (int c = 0; c < CH; c++) begin
      e_do[c*W +: W] = m_data[c];
      e_cap[c] = m_cap[c];
      e_ovr[c] = m_ovr[c];
    end
    chk("data_out", data_out, e_do);
    chk("captured", captured, e_cap);
    chk("overrun",  overrun,  e_ovr);
    chk("rd_valid", rd_valid, m_valid);
    chk("rd_chan",  rd_chan,  m_chan);
    chk("rd_data",  rd_data,  m_rdata);
  endtask

  // Called at a falling edge with inputs already set.
  task automatic cycle();
    if (rd_valid && rd_ready) words.push_back(int'(rd_chan));
    m_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    #1;
    compare();
    @(posedge clk);
    @(negedge clk);
    compare();
    reset = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] v);
    data_in[c*W +: W] = v;
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (words.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, words.size() >= n, 1'b1);
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    @(negedge clk);
    compare();
    reset = 1'b0;

    // Reset while a word is on offer.
    mode = 2'b00; enable = 4'b0010; set_ch(1, 8'h3C); cycle();
    enable = '0; cycle();
    chk("pre_reset_valid", rd_valid, 1'b1);
    do_reset();
    cycle(); cycle();
    chk("post_reset_cap", captured, 4'b0000);
    chk("post_reset_valid", rd_valid, 1'b0);

    // FOLLOW tracks with one-cycle latency; unread value overruns.
    do_clear();
    rd_ready = 1'b0; mode = 2'b00; enable = 4'b0001;
    set_ch(0, 8'h11); cycle();
    chk("follow_lat", data_out[7:0], 8'h11);
    set_ch(0, 8'h22); cycle();
    set_ch(0, 8'h33); cycle();
    enable = '0;
    chk("follow_end", data_out[7:0], 8'h33);
    chk("follow_ovr", overrun[0], 1'b1);

    // SAMPLE captures only the rising edge.
    do_clear();
    mode = 2'b01; enable = '0; cycle();
    enable = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      set_ch(2, 8'hA0 + 8'(i)); cycle();
    end
    enable = '0;
    chk("sample_cap", captured, 4'b0100);
    chk("sample_data", data_out[23:16], 8'hA0);
    chk("sample_valid", rd_valid, 1'b1);
    chk("sample_chan", rd_chan, 2'd2);
    chk("sample_rd", rd_data, 8'hA0);

    // Round robin order and pointer wrap.
    do_clear();
    words.delete();
    mode = 2'b00; rd_ready = 1'b1;
    enable = 4'b1010; set_ch(1, 8'h01); set_ch(3, 8'h03); cycle();
    enable = '0;
    wait_words("rr_two", 2, 12);
    if (words.size() >= 2) begin
      chk("rr_first", words[0], 1);
      chk("rr_second", words[1], 3);
    end
    cycle();
    enable = 4'b0011; set_ch(0, 8'h10); set_ch(1, 8'h11); cycle();
    enable = '0;
    wait_words("rr_three", 3, 12);
    if (words.size() >= 3) chk("rr_wrap", words[2], 0);
    for (int i = 0; i < 6; i++) cycle();
    rd_ready = 1'b0;

    // Backpressure, snapshot and a capture colliding with the accept.
    do_clear();
    mode = 2'b00; rd_ready = 1'b0;
    enable = 4'b0001; set_ch(0, 8'h55); cycle();
    enable = '0; cycle();
    enable = 4'b0001; set_ch(0, 8'h66); cycle();
    enable = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_snapshot", rd_data, 8'h55);
    end
    chk("bp_ovr", overrun[0], 1'b1);
    rd_ready = 1'b1; enable = 4'b0001; set_ch(0, 8'h77); cycle();
    enable = '0; rd_ready = 1'b0;
    chk("bp_collide_cap", captured[0], 1'b1);
    chk("bp_collide_valid", rd_valid, 1'b0);
    cycle();
    chk("bp_repres_valid", rd_valid, 1'b1);
    chk("bp_repres_data", rd_data, 8'h77);
    rd_ready = 1'b1; cycle(); rd_ready = 1'b0;

    do_clear();
    enable = 4'b0010; set_ch(1, 8'h12); cycle();
    enable = '0; cycle();
    rd_ready = 1'b1; enable = 4'b0010; set_ch(1, 8'h34); cycle();
    enable = '0; rd_ready = 1'b0;
    chk("collide_no_ovr", overrun[1], 1'b0);
    chk("collide_keep_cap", captured[1], 1'b1);

    // FREEZE holds data; clear aborts the offered word.
    do_clear();
    mode = 2'b00; enable = 4'b1100; set_ch(2, 8'h5A); set_ch(3, 8'hC3); cycle();
    mode = 2'b10;
    for (int i = 0; i < 6; i++) begin
      enable = CH'($urandom); data_in = $urandom; cycle();
    end
    chk("freeze_hold", data_out, 32'hC35A_0000);
    chk("freeze_valid", rd_valid, 1'b1);
    do_clear();
    chk("clear_valid", rd_valid, 1'b0);
    chk("clear_data", data_out, 32'h0);
    chk("clear_cap", captured, 4'b0000);
    chk("clear_ovr", overrun, 4'b0000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      enable   = CH'($urandom);
      data_in  = $urandom;
      rd_ready = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) begin
        clear = 1'b0;
        do_reset();
      end else begin
        cycle();
      end
    end
    clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
